// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: hex display driver with static and multiplexed outputs, leading-zero suppression and blinking
module seg7_scan_driver #(
  parameter int NDIGIT = 6,
  parameter int SCAN_DIV = 50000,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*NDIGIT-1:0]   data_in,
  input  logic                  load,
  input  logic                  lz_en,
  input  logic [NDIGIT-1:0]     blink_mask,
  output logic [7*NDIGIT-1:0]   hex_all,
  output logic [6:0]            seg,
  output logic [NDIGIT-1:0]     dig_n
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int IW = NDIGIT > 1 ? $clog2(NDIGIT) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);
  localparam logic [IW-1:0] IMAX = IW'(NDIGIT - 1);
  logic [4*NDIGIT-1:0] data_q, data_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [BW-1:0]       blink_q, blink_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic                phase_q, phase_d;
  logic [7*NDIGIT-1:0] hex_q, hex_d;
  logic [6:0]          seg_q, seg_d;
  logic [NDIGIT-1:0]   dig_n_q, dig_n_d;
  logic [6:0]          glyph_w [NDIGIT];
  logic                tick, bwrap;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction
  // Per-digit glyphs: zero chain runs from the top digit down; digit 0 is never suppressed
  always_comb begin
    logic za;
    logic blank;
    za = 1'b1;
    blank = 1'b0;
    hex_d = '0;
    for (int i = NDIGIT - 1; i >= 0; i--) begin
      za = za && (data_q[4*i +: 4] == 4'h0);
      blank = (lz_en && i != 0 && za) || (phase_q && blink_mask[i]);
      glyph_w[i] = blank ? 7'h7F : glyph(data_q[4*i +: 4]);
      hex_d[7*i +: 7] = glyph_w[i];
    end
  end
  // Next state: prescaler, scan index, blink timer, and the ghost-blank slot on each tick
  always_comb begin
    tick = pre_q == PMAX;
    bwrap = blink_q == BMAX;
    data_d = load ? data_in : data_q;
    pre_d = tick ? '0 : pre_q + PW'(1);
    idx_d = tick ? (idx_q == IMAX ? '0 : idx_q + IW'(1)) : idx_q;
    blink_d = bwrap ? '0 : blink_q + BW'(1);
    phase_d = phase_q ^ bwrap;
    seg_d = tick ? 7'h7F : glyph_w[idx_q];
    dig_n_d = tick ? '1 : ~(NDIGIT'(1) << idx_q);
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      hex_q <= '1;
      seg_q <= 7'h7F;
      dig_n_q <= '1;
    end else begin
      data_q <= data_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      hex_q <= hex_d;
      seg_q <= seg_d;
      dig_n_q <= dig_n_d;
    end
  end
  assign hex_all = hex_q;
  assign seg = seg_q;
  assign dig_n = dig_n_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized check of seg7_scan_driver against a cycle-count reference model
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] data_in = '0;
  logic load = 1'b0;
  logic lz_en = 1'b0;
  logic [3:0] blink_mask = '0;
  logic [27:0] hex_all;
  logic [6:0] seg;
  logic [3:0] dig_n;
  int n_cmp = 0;
  int n_bad = 0;
  int n = 0;
  logic [15:0] m_data = '0;
  logic [6:0] gl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  seg7_scan_driver #(.NDIGIT(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load(load), .lz_en(lz_en),
    .blink_mask(blink_mask), .hex_all(hex_all), .seg(seg), .dig_n(dig_n)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  function automatic logic [6:0] mglyph(input int i);
    logic [15:0] upper;
    logic blank;
    upper = m_data >> (4 * i);
    blank = (lz_en && i != 0 && upper == 16'h0) || (((n / BD) % 2 == 1) && blink_mask[i]);
    return blank ? 7'h7F : gl[upper[3:0]];
  endfunction
  task automatic step();
    logic [27:0] eh;
    logic [6:0] es;
    logic [3:0] ed;
    int idx;
    idx = (n / SD) % ND;
    for (int i = 0; i < ND; i++) eh[7*i +: 7] = mglyph(i);
    es = (n % SD == SD - 1) ? 7'h7F : mglyph(idx);
    ed = (n % SD == SD - 1) ? 4'hF : ~(4'b0001 << idx);
    if (rst) begin
      eh = '1;
      es = 7'h7F;
      ed = 4'hF;
    end
    @(posedge clk);
    #1;
    chk("hex_all", 32'(hex_all), 32'(eh));
    chk("seg", 32'(seg), 32'(es));
    chk("dig_n", 32'(dig_n), 32'(ed));
    if (rst) begin
      n = 0;
      m_data = '0;
    end else begin
      n++;
      if (load) m_data = data_in;
    end
  endtask
  task automatic do_load(input logic [15:0] v);
    data_in = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dig", 32'(dig_n), 32'hF);
    rst = 1'b0;
    step();
    chk("rel_hex", 32'(hex_all), 32'({4{7'b1000000}}));
    chk("rel_dig", 32'(dig_n), 32'b1110);
    do_load(16'h1A2F);
    step();
    chk("ld_hex", 32'(hex_all), 32'({7'b1111001, 7'b0001000, 7'b0100100, 7'b0001110}));
    repeat (20) step();
    lz_en = 1'b1;
    do_load(16'h0050);
    repeat (6) step();
    do_load(16'h0000);
    repeat (6) step();
    chk("lz_zero", 32'(hex_all), 32'({7'h7F, 7'h7F, 7'h7F, 7'b1000000}));
    do_load(16'h1000);
    repeat (6) step();
    lz_en = 1'b0;
    blink_mask = 4'b0010;
    do_load(16'h1234);
    repeat (40) step();
    blink_mask = 4'b0000;
    while ((n / SD) % ND != 2 || n % SD == SD - 1) step();
    rst = 1'b1;
    step();
    chk("mid_rst_hex", 32'(hex_all), 32'hFFFFFFF);
    rst = 1'b0;
    repeat (6) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    do_load(16'h00C0);
    step();
    chk("tick_load", 32'(seg), 32'(7'b1000110));
    repeat (3) step();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      load = ($urandom_range(0, 5) == 0);
      data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00FF;
      if ($urandom_range(0, 19) == 0) lz_en = ~lz_en;
      if ($urandom_range(0, 29) == 0) blink_mask = 4'($urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
